tmds_encoder: RTL and testbench

- Downstream stage of the 640x480 video timing controller.
- Consumes the per-pixel DE, HSYNC, VSYNC and 8-bit RED/GREEN/BLUE from the timing controller on the pixel clock.
- Produces three 10-bit DVI/HDMI TMDS symbols per clock: channel 0 = blue, channel 1 = green, channel 2 = red. It applies transition minimisation and DC balancing with a per-channel running-disparity counter.
- Output feeds the 10:1 serialiser.

---
 rtl/tmds_encoder.sv | 148 ++++++++++++++
 tb/tb_tmds_encoder.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tmds_encoder.sv
// rtl/tmds_encoder.sv - three-channel DVI/HDMI TMDS encoder, two-stage pipeline
module tmds_encoder #(
  parameter bit INVERT_SYNC = 1'b0
) (
  input  logic       CLK_PX,
  input  logic       RST_n,
  input  logic       DE,
  input  logic       HSYNC,
  input  logic       VSYNC,
  input  logic [7:0] RED,
  input  logic [7:0] GREEN,
  input  logic [7:0] BLUE,
  output logic [9:0] TMDS_CH0,
  output logic [9:0] TMDS_CH1,
  output logic [9:0] TMDS_CH2,
  output logic       DE_OUT
);

  localparam logic [9:0] CTRL_00 = 10'h354;
  localparam logic [9:0] CTRL_01 = 10'h0AB;
  localparam logic [9:0] CTRL_10 = 10'h154;
  localparam logic [9:0] CTRL_11 = 10'h2AB;

  // Population count of a byte
  function automatic logic [3:0] ones8(input logic [7:0] d);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'b000, d[i]};
    end
    return n;
  endfunction

  // Transition-minimised 9-bit word; bit 8 = 1 marks the XOR path
  function automatic logic [8:0] minimise(input logic [7:0] d);
    logic [3:0] n1;
    logic       use_xnor;
    logic [8:0] q;
    n1       = ones8(d);
    use_xnor = (n1 > 4'd4) || ((n1 == 4'd4) && !d[0]);
    q        = 9'd0;
    q[0]     = d[0];
    for (int i = 1; i < 8; i++) begin
      q[i] = use_xnor ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
    end
    q[8] = ~use_xnor;
    return q;
  endfunction

  // Control symbol for {C1, C0}
  function automatic logic [9:0] ctrl_sym(input logic [1:0] c);
    logic [9:0] s;
    case (c)
      2'b00:   s = CTRL_00;
      2'b01:   s = CTRL_01;
      2'b10:   s = CTRL_10;
      default: s = CTRL_11;
    endcase
    return s;
  endfunction

  // DC balancing: returns {symbol[9:0], next disparity[4:0]}
  function automatic logic [14:0] dc_balance(
    input logic              de,
    input logic [9:0]        ctrl,
    input logic [8:0]        qm,
    input logic signed [4:0] cnt
  );
    logic [3:0]        n1;
    logic signed [4:0] diff;   // ones minus zeros of qm[7:0]
    logic [9:0]        sym;
    logic signed [4:0] cnt_n;
    n1   = ones8(qm[7:0]);
    diff = $signed({n1, 1'b0}) - 5'sd8;
    if (!de) begin
      sym   = ctrl;
      cnt_n = 5'sd0;
    end else if ((cnt == 5'sd0) || (diff == 5'sd0)) begin
      sym   = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
      cnt_n = qm[8] ? (cnt + diff) : (cnt - diff);
    end else if (((cnt > 5'sd0) && (diff > 5'sd0)) || ((cnt < 5'sd0) && (diff < 5'sd0))) begin
      sym   = {1'b1, qm[8], ~qm[7:0]};
      cnt_n = cnt + (qm[8] ? 5'sd2 : 5'sd0) - diff;
    end else begin
      sym   = {1'b0, qm[8], qm[7:0]};
      cnt_n = cnt + diff - (qm[8] ? 5'sd0 : 5'sd2);
    end
    return {sym, cnt_n};
  endfunction

  logic              de_s1;
  logic [1:0]        ctl_s1;
  logic [8:0]        qm0_s1;
  logic [8:0]        qm1_s1;
  logic [8:0]        qm2_s1;
  logic signed [4:0] cnt0;
  logic signed [4:0] cnt1;
  logic signed [4:0] cnt2;
  logic [14:0]       enc0;
  logic [14:0]       enc1;
  logic [14:0]       enc2;

  // Stage 1: capture DE and sync bits, transition-minimise each colour byte
  always_ff @(posedge CLK_PX or negedge RST_n) begin
    if (!RST_n) begin
      de_s1  <= 1'b0;
      ctl_s1 <= 2'b00;
      qm0_s1 <= 9'd0;
      qm1_s1 <= 9'd0;
      qm2_s1 <= 9'd0;
    end else begin
      de_s1  <= DE;
      ctl_s1 <= {VSYNC ^ INVERT_SYNC, HSYNC ^ INVERT_SYNC};
      qm0_s1 <= minimise(BLUE);
      qm1_s1 <= minimise(GREEN);
      qm2_s1 <= minimise(RED);
    end
  end

  // Stage 2 combinational: per-channel DC balance against its own disparity
  always_comb begin
    enc0 = dc_balance(de_s1, ctrl_sym(ctl_s1), qm0_s1, cnt0);
    enc1 = dc_balance(de_s1, CTRL_00, qm1_s1, cnt1);
    enc2 = dc_balance(de_s1, CTRL_00, qm2_s1, cnt2);
  end

  // Stage 2: register symbols, disparity counters and aligned DE
  always_ff @(posedge CLK_PX or negedge RST_n) begin
    if (!RST_n) begin
      TMDS_CH0 <= CTRL_00;
      TMDS_CH1 <= CTRL_00;
      TMDS_CH2 <= CTRL_00;
      DE_OUT   <= 1'b0;
      cnt0     <= 5'sd0;
      cnt1     <= 5'sd0;
      cnt2     <= 5'sd0;
    end else begin
      TMDS_CH0 <= enc0[14:5];
      TMDS_CH1 <= enc1[14:5];
      TMDS_CH2 <= enc2[14:5];
      DE_OUT   <= de_s1;
      cnt0     <= $signed(enc0[4:0]);
      cnt1     <= $signed(enc1[4:0]);
      cnt2     <= $signed(enc2[4:0]);
    end
  end

endmodule

// File: tb/tb_tmds_encoder.sv
// tb/tb_tmds_encoder.sv - directed self-checking bench for tmds_encoder
module tb_tmds_encoder;

  logic       CLK_PX = 1'b0;
  logic       RST_n;
  logic       DE;
  logic       HSYNC;
  logic       VSYNC;
  logic [7:0] RED;
  logic [7:0] GREEN;
  logic [7:0] BLUE;
  logic [9:0] TMDS_CH0;
  logic [9:0] TMDS_CH1;
  logic [9:0] TMDS_CH2;
  logic       DE_OUT;
  logic [9:0] inv_ch0;
  logic [9:0] inv_ch1;
  logic [9:0] inv_ch2;
  logic       inv_de;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 CLK_PX = ~CLK_PX;

  tmds_encoder #(.INVERT_SYNC(1'b0)) dut (
    .CLK_PX(CLK_PX), .RST_n(RST_n), .DE(DE), .HSYNC(HSYNC), .VSYNC(VSYNC),
    .RED(RED), .GREEN(GREEN), .BLUE(BLUE),
    .TMDS_CH0(TMDS_CH0), .TMDS_CH1(TMDS_CH1), .TMDS_CH2(TMDS_CH2), .DE_OUT(DE_OUT)
  );

  tmds_encoder #(.INVERT_SYNC(1'b1)) dut_inv (
    .CLK_PX(CLK_PX), .RST_n(RST_n), .DE(DE), .HSYNC(HSYNC), .VSYNC(VSYNC),
    .RED(RED), .GREEN(GREEN), .BLUE(BLUE),
    .TMDS_CH0(inv_ch0), .TMDS_CH1(inv_ch1), .TMDS_CH2(inv_ch2), .DE_OUT(inv_de)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK_PX);
    #1;
  endtask

  task automatic drive(input logic de, input logic h, input logic v,
                       input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    DE = de; HSYNC = h; VSYNC = v; RED = r; GREEN = g; BLUE = b;
  endtask

  logic       v_de[8];
  logic       v_h[8];
  logic       v_v[8];
  logic [7:0] v_r[8];
  logic [7:0] v_g[8];
  logic [7:0] v_b[8];
  logic [9:0] x0[8];
  logic [9:0] x1[8];
  logic [9:0] x2[8];
  logic       xd[8];

  task automatic set_vec(input int i, input logic de, input logic h, input logic v,
                         input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                         input logic [9:0] e0, input logic [9:0] e1, input logic [9:0] e2,
                         input logic ed);
    v_de[i] = de; v_h[i] = h; v_v[i] = v; v_r[i] = r; v_g[i] = g; v_b[i] = b;
    x0[i] = e0; x1[i] = e1; x2[i] = e2; xd[i] = ed;
  endtask

  // Streams n vectors; the output after the second edge belongs to the vector one slot back
  task automatic run_vec(input int n, input string tag);
    for (int i = 0; i <= n; i++) begin
      if (i < n) drive(v_de[i], v_h[i], v_v[i], v_r[i], v_g[i], v_b[i]);
      tick();
      if (i >= 1) begin
        chk($sformatf("%s%0d_ch0", tag, i-1), TMDS_CH0, x0[i-1]);
        chk($sformatf("%s%0d_ch1", tag, i-1), TMDS_CH1, x1[i-1]);
        chk($sformatf("%s%0d_ch2", tag, i-1), TMDS_CH2, x2[i-1]);
        chk($sformatf("%s%0d_de", tag, i-1), DE_OUT, xd[i-1]);
      end
    end
  endtask

  int mcnt[3];

  // Reference encoder written straight from the DVI algorithm, integer arithmetic
  function automatic logic [9:0] ref_sym(input int ch, input logic de, input logic c1,
                                         input logic c0, input logic [7:0] d);
    int         ones;
    int         qo;
    int         qz;
    logic       xn;
    logic [8:0] q;
    logic [9:0] s;
    if (!de) begin
      mcnt[ch] = 0;
      if (ch != 0) s = 10'h354;
      else if (!c1 && !c0) s = 10'h354;
      else if (!c1 && c0) s = 10'h0AB;
      else if (c1 && !c0) s = 10'h154;
      else s = 10'h2AB;
    end else begin
      ones = $countones(d);
      xn   = (ones > 4) || (ones == 4 && d[0] == 1'b0);
      q    = '0;
      q[0] = d[0];
      for (int i = 1; i < 8; i++) q[i] = xn ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
      q[8] = !xn;
      qo = $countones(q[7:0]);
      qz = 8 - qo;
      if (mcnt[ch] == 0 || qo == qz) begin
        s = {~q[8], q[8], q[8] ? q[7:0] : ~q[7:0]};
        mcnt[ch] = mcnt[ch] + (q[8] ? (qo - qz) : (qz - qo));
      end else if ((mcnt[ch] > 0 && qo > qz) || (mcnt[ch] < 0 && qz > qo)) begin
        s = {1'b1, q[8], ~q[7:0]};
        mcnt[ch] = mcnt[ch] + (q[8] ? 2 : 0) + (qz - qo);
      end else begin
        s = {1'b0, q[8], q[7:0]};
        mcnt[ch] = mcnt[ch] + (qo - qz) - (q[8] ? 0 : 2);
      end
    end
    return s;
  endfunction

  initial begin
    logic [9:0] p0, p1, p2, e0, e1, e2;
    logic       pd, pfirst, first_seen;
    logic [9:0] first0, first1, first2;
    logic [9:0] pf0, pf1, pf2;
    int         px;
    logic       de_l, h_l;
    logic [7:0] r_l, g_l, b_l;

    RST_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    repeat (3) tick();
    chk("rst_ch0", TMDS_CH0, 10'h354);
    chk("rst_ch1", TMDS_CH1, 10'h354);
    chk("rst_ch2", TMDS_CH2, 10'h354);
    chk("rst_de", DE_OUT, 1'b0);
    chk("rst_inv_ch0", inv_ch0, 10'h354);
    RST_n = 1'b1;
    repeat (2) tick();

    drive(1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00);
    repeat (2) tick();
    chk("ctl_v_ch0", TMDS_CH0, 10'h154);
    chk("ctl_v_ch1", TMDS_CH1, 10'h354);
    chk("ctl_v_ch2", TMDS_CH2, 10'h354);
    chk("ctl_v_inv", inv_ch0, 10'h0AB);
    drive(1'b0, 1'b1, 1'b1, 8'h00, 8'h00, 8'h00);
    repeat (2) tick();
    chk("ctl_hv_ch0", TMDS_CH0, 10'h2AB);
    chk("ctl_hv_inv", inv_ch0, 10'h354);
    drive(1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
    repeat (2) tick();
    chk("ctl_h_ch0", TMDS_CH0, 10'h0AB);
    chk("ctl_h_inv", inv_ch0, 10'h154);
    drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    repeat (2) tick();
    chk("ctl_0_ch0", TMDS_CH0, 10'h354);
    chk("ctl_0_inv", inv_ch0, 10'h2AB);
    chk("ctl_0_inv_ch1", inv_ch1, 10'h354);
    chk("ctl_0_inv_de", inv_de, 1'b0);

    // Disparity walk: blue/green 00 vs red FF, sync toggles inside DE are ignored
    set_vec(0, 1'b1, 1'b0, 1'b0, 8'hFF, 8'h00, 8'h00, 10'h100, 10'h100, 10'h200, 1'b1);
    set_vec(1, 1'b1, 1'b1, 1'b0, 8'hFF, 8'h00, 8'h00, 10'h3FF, 10'h3FF, 10'h0FF, 1'b1);
    set_vec(2, 1'b1, 1'b0, 1'b0, 8'hFF, 8'h00, 8'h00, 10'h100, 10'h100, 10'h0FF, 1'b1);
    set_vec(3, 1'b1, 1'b0, 1'b1, 8'hFF, 8'h00, 8'h00, 10'h3FF, 10'h3FF, 10'h200, 1'b1);
    set_vec(4, 1'b0, 1'b0, 1'b1, 8'hFF, 8'h00, 8'h00, 10'h154, 10'h354, 10'h354, 1'b0);
    run_vec(5, "disp");

    // Single-cycle DE pulse after blanking: disparity restarts from zero
    set_vec(0, 1'b1, 1'b0, 1'b0, 8'hFF, 8'h00, 8'h00, 10'h100, 10'h100, 10'h200, 1'b1);
    set_vec(1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 10'h354, 10'h354, 10'h354, 1'b0);
    set_vec(2, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 10'h0AB, 10'h354, 10'h354, 1'b0);
    run_vec(3, "pulse");

    // Asynchronous reset in the middle of active video
    drive(1'b1, 1'b0, 1'b0, 8'hFF, 8'h00, 8'h00);
    repeat (3) tick();
    chk("mid_pre_de", DE_OUT, 1'b1);
    #2 RST_n = 1'b0;
    #1;
    chk("mid_rst_ch0", TMDS_CH0, 10'h354);
    chk("mid_rst_ch1", TMDS_CH1, 10'h354);
    chk("mid_rst_ch2", TMDS_CH2, 10'h354);
    chk("mid_rst_de", DE_OUT, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    tick();
    RST_n = 1'b1;
    repeat (3) tick();

    // Two incrementing-colour lines against the reference encoder
    mcnt[0] = 0; mcnt[1] = 0; mcnt[2] = 0;
    p0 = 10'h354; p1 = 10'h354; p2 = 10'h354; pd = 1'b0; pfirst = 1'b0;
    first_seen = 1'b0;
    first0 = '0; first1 = '0; first2 = '0;
    pf0 = '0; pf1 = '0; pf2 = '0;
    for (int line = 0; line < 2; line++) begin
      for (int i = 0; i < 40; i++) begin
        px   = i - 4;
        de_l = (i >= 4) && (i < 36);
        h_l  = (i >= 37) && (i < 39);
        r_l  = 8'(px * 8);
        g_l  = 8'(px * 5 + 3);
        b_l  = 8'(255 - px * 7);
        drive(de_l, h_l, 1'b0, r_l, g_l, b_l);
        e0 = ref_sym(0, de_l, 1'b0, h_l, b_l);
        e1 = ref_sym(1, de_l, 1'b0, 1'b0, g_l);
        e2 = ref_sym(2, de_l, 1'b0, 1'b0, r_l);
        tick();
        chk($sformatf("line%0d_%0d_ch0", line, i), TMDS_CH0, p0);
        chk($sformatf("line%0d_%0d_ch1", line, i), TMDS_CH1, p1);
        chk($sformatf("line%0d_%0d_ch2", line, i), TMDS_CH2, p2);
        chk($sformatf("line%0d_%0d_de", line, i), DE_OUT, pd);
        if (pfirst) begin
          chk("line_repeat_ch0", TMDS_CH0, pf0);
          chk("line_repeat_ch1", TMDS_CH1, pf1);
          chk("line_repeat_ch2", TMDS_CH2, pf2);
        end
        pfirst = 1'b0;
        if (de_l && px == 0) begin
          if (first_seen) begin
            pfirst = 1'b1;
            pf0 = first0; pf1 = first1; pf2 = first2;
          end else begin
            first_seen = 1'b1;
            first0 = e0; first1 = e1; first2 = e2;
          end
        end
        p0 = e0; p1 = e1; p2 = e2; pd = de_l;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
